// File: rtl/jtdsp16_sio_pkg.sv
// Shared definitions for the DSP16 TDM serial output port.
//   sio_state_e  : transmitter state encoding (idle, word load, bit shifting)
//   slot_width   : width of the TDM slot counter for a given slot count (minimum 1)
//   bitcnt_width : width of the per-word bit counter for a given word width
package jtdsp16_sio_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2
    } sio_state_e;

    function automatic int unsigned slot_width(input int unsigned ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    function automatic int unsigned bitcnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/jtdsp16_sio_fifo.sv
// Synchronous FIFO for the serial output port, qualified by the cen clock enable.
//   clk, rst_n, cen : clock, async active-low reset, clock enable
//   push, din       : enqueue request and data
//   pop             : dequeue request (ignored when empty)
//   dout            : head entry (valid when not empty)
//   full, empty     : occupancy status
//   cnt             : number of stored entries
//   ovf             : push dropped because the FIFO was full with no pop this tick
module jtdsp16_sio_fifo #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   cnt,
    output logic          ovf
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    always_comb begin
        full    = (cnt_q == (AW+1)'(DEPTH));
        empty   = (cnt_q == '0);
        pop_ok  = pop && !empty;
        // A full FIFO still takes a write when the head leaves in the same tick
        push_ok = push && (!full || pop_ok);
        ovf     = cen && push && full && !pop_ok;
        dout    = mem[rd_ptr_q];
        cnt     = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (cen) begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (!push_ok && pop_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (cen && push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/jtdsp16_sio_tdm.sv
// DSP16 serial output port with FIFO and time-division-multiplexed framing.
//   clk, rst_n, cen      : clock, async active-low reset, clock enable (cen2)
//   en                   : transmitter enable
//   clk_div              : half bit period minus one, in cen ticks
//   len8, lsb_first      : word length select and shift order (latched per word)
//   wr, wr_data          : CPU write into the FIFO
//   clr_flags            : clears underrun/overflow
//   sdo, ock, old, fs    : serial data, bit clock, word-load strobe, frame sync
//   ose, obe, fifo_cnt   : shifter idle, FIFO not full, FIFO occupancy
//   underrun, overflow   : sticky error flags
module jtdsp16_sio_tdm
    import jtdsp16_sio_pkg::*;
#(
    parameter int unsigned DW      = 16,
    parameter int unsigned CH      = 2,
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned DIVW    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               en,
    input  logic [DIVW-1:0]    clk_div,
    input  logic               len8,
    input  logic               lsb_first,
    input  logic               wr,
    input  logic [DW-1:0]      wr_data,
    input  logic               clr_flags,
    output logic               sdo,
    output logic               ock,
    output logic               old,
    output logic               fs,
    output logic               ose,
    output logic               obe,
    output logic [FIFO_AW:0]   fifo_cnt,
    output logic               underrun,
    output logic               overflow
);
    localparam int unsigned SW = slot_width(CH);
    localparam int unsigned BW = bitcnt_width(DW);
    localparam logic [BW-1:0] LAST_W    = BW'(DW - 1);
    localparam logic [BW-1:0] LAST_8    = BW'(7);
    localparam logic [SW-1:0] LAST_SLOT = SW'(CH - 1);

    sio_state_e      state_q;
    logic [SW-1:0]   slot_q;
    logic [BW-1:0]   bit_q;
    logic [DIVW-1:0] div_q, divcnt_q;
    logic            len8_q, lsb_q;
    logic [DW-1:0]   shr_q;
    logic            sdo_q, ock_q, under_q, over_q;

    logic [DW-1:0]   fifo_dout, ld_word, shift_nxt;
    logic            fifo_full, fifo_empty, fifo_ovf;
    logic            last_bit, half_done, under_set;
    logic [SW-1:0]   slot_nxt;

    jtdsp16_sio_fifo #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .push  (wr),
        .din   (wr_data),
        .pop   (state_q == StLoad),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_cnt),
        .ovf   (fifo_ovf)
    );

    always_comb begin
        // 8-bit words are placed so that the first bit to go out sits at the shift end
        if (fifo_empty)     ld_word = '0;
        else if (!len8)     ld_word = fifo_dout;
        else if (lsb_first) ld_word = DW'(fifo_dout[7:0]);
        else                ld_word = DW'(fifo_dout[7:0]) << (DW - 8);
        shift_nxt = lsb_q ? (shr_q >> 1) : (shr_q << 1);
        last_bit  = (bit_q == (len8_q ? LAST_8 : LAST_W));
        half_done = (divcnt_q == div_q);
        slot_nxt  = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        under_set = cen && (state_q == StLoad) && fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            slot_q   <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            divcnt_q <= '0;
            len8_q   <= 1'b0;
            lsb_q    <= 1'b0;
            shr_q    <= '0;
            sdo_q    <= 1'b0;
            ock_q    <= 1'b0;
        end else if (cen) begin
            unique case (state_q)
                StIdle: begin
                    sdo_q  <= 1'b0;
                    ock_q  <= 1'b0;
                    slot_q <= '0;
                    if (en && !fifo_empty) state_q <= StLoad;
                end
                StLoad: begin
                    shr_q    <= ld_word;
                    sdo_q    <= lsb_first ? ld_word[0] : ld_word[DW-1];
                    len8_q   <= len8;
                    lsb_q    <= lsb_first;
                    div_q    <= clk_div;
                    divcnt_q <= '0;
                    bit_q    <= '0;
                    ock_q    <= 1'b0;
                    state_q  <= StShift;
                end
                StShift: begin
                    if (!half_done) begin
                        divcnt_q <= divcnt_q + 1'b1;
                    end else begin
                        divcnt_q <= '0;
                        if (!ock_q) begin
                            ock_q <= 1'b1;
                        end else begin
                            ock_q <= 1'b0;
                            if (!last_bit) begin
                                bit_q <= bit_q + 1'b1;
                                shr_q <= shift_nxt;
                                sdo_q <= lsb_q ? shift_nxt[0] : shift_nxt[DW-1];
                            end else if (en) begin
                                // sdo holds the last bit through the LOAD tick
                                slot_q  <= slot_nxt;
                                state_q <= StLoad;
                            end else begin
                                slot_q  <= '0;
                                sdo_q   <= 1'b0;
                                state_q <= StIdle;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Set wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            under_q <= 1'b0;
            over_q  <= 1'b0;
        end else if (cen) begin
            under_q <= under_set | (under_q & ~clr_flags);
            over_q  <= fifo_ovf  | (over_q  & ~clr_flags);
        end
    end

    always_comb begin
        sdo      = sdo_q;
        ock      = ock_q;
        old      = (state_q == StLoad);
        fs       = (state_q == StLoad) && (slot_q == '0);
        ose      = (state_q == StIdle);
        obe      = !fifo_full;
        underrun = under_q;
        overflow = over_q;
    end

endmodule

// File: tb/tb_jtdsp16_sio_tdm.sv
module tb_jtdsp16_sio_tdm;
    localparam int DW = 16, CH = 2, AW = 2, DIVW = 4, DEPTH = 4;

    logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, en = 1'b0;
    logic len8 = 1'b0, lsb_first = 1'b0, wr = 1'b0, clr_flags = 1'b0;
    logic [DIVW-1:0] clk_div = '0;
    logic [DW-1:0]   wr_data = '0;
    logic sdo, ock, old, fs, ose, obe, underrun, overflow;
    logic [AW:0] fifo_cnt;

    always #5 clk = ~clk;

    jtdsp16_sio_tdm #(.DW(DW), .CH(CH), .FIFO_AW(AW), .DIVW(DIVW)) dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .en(en), .clk_div(clk_div), .len8(len8),
        .lsb_first(lsb_first), .wr(wr), .wr_data(wr_data), .clr_flags(clr_flags),
        .sdo(sdo), .ock(ock), .old(old), .fs(fs), .ose(ose), .obe(obe),
        .fifo_cnt(fifo_cnt), .underrun(underrun), .overflow(overflow)
    );

    int n_tests = 0, n_fail = 0;

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: FIFO occupancy, queue of words to be sent, sticky flags
    int mcnt = 0;
    logic [DW-1:0] mq[$];
    bit m_under = 0, m_over = 0, pend_under = 0, gaps = 0, cur_load = 0;
    int tick_no = 0;
    // Word observer state
    bit in_word = 0, have_prev = 0, saw_idle = 1, prev_ock = 0;
    int bit_idx = 0, run = 0, mslot = 0, nb = 16, last_load = 0, prev_nb = 16, prev_div = 0;
    int w_div = 0, old_tick = -1, n_loads = 0;
    bit w_lsb = 0;
    logic [DW-1:0] rx = '0, exp_w = '0;

    task automatic monitor();
        check_eq("fifo_cnt", fifo_cnt, mcnt);
        check_eq("obe", obe, mcnt < DEPTH);
        check_eq("underrun", underrun, m_under);
        check_eq("overflow", overflow, m_over);
        if (in_word && ock != prev_ock) begin
            check_eq("ock_half", run, w_div + 1);
            run = 1;
            if (ock) begin
                if (bit_idx < nb) begin
                    if (w_lsb) rx[bit_idx] = sdo;
                    else       rx[nb-1-bit_idx] = sdo;
                end
                bit_idx++;
            end else if (bit_idx >= nb) begin
                check_eq("word", rx, exp_w);
                in_word = 0;
                mslot = (mslot == CH - 1) ? 0 : mslot + 1;
                prev_nb = nb;
                prev_div = w_div;
            end
        end else if (in_word) begin
            run++;
        end
        prev_ock = ock;
        cur_load = old;
        if (old) begin
            check_eq("word_cut", in_word, 0);
            check_eq("fs", fs, mslot == 0);
            if (have_prev && !saw_idle)
                check_eq("load_gap", tick_no - last_load, 1 + prev_nb * 2 * (prev_div + 1));
            have_prev = 1; saw_idle = 0; last_load = tick_no; old_tick = tick_no; n_loads++;
            if (mq.size() > 0) exp_w = mq.pop_front();
            else begin exp_w = '0; pend_under = 1; end
            nb = len8 ? 8 : DW;
            if (len8) exp_w = exp_w & DW'(8'hFF);
            w_lsb = lsb_first; w_div = int'(clk_div);
            in_word = 1; bit_idx = 0; rx = '0; run = 0; prev_ock = 0;
        end else begin
            check_eq("fs_low", fs, 0);
        end
        if (ose) begin
            check_eq("idle_sdo", sdo, 0);
            check_eq("idle_ock", ock, 0);
            check_eq("idle_in_word", in_word, 0);
            mslot = 0; saw_idle = 1;
        end
    endtask

    // One cen tick, optionally preceded by gated cycles carrying junk strobes
    task automatic tick(input bit w, input logic [DW-1:0] d, input bit c);
        bit pop_now, acc;
        if (gaps) repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            cen = 0; wr = 1'($urandom_range(0, 1)); clr_flags = 1'($urandom_range(0, 1));
            wr_data = DW'($urandom);
        end
        @(negedge clk);
        cen = 1; wr = w; wr_data = d; clr_flags = c;
        @(posedge clk);
        pop_now = cur_load && (mcnt > 0);
        acc = w && (mcnt < DEPTH || pop_now);
        if (acc) mq.push_back(d);
        mcnt = mcnt + int'(acc) - int'(pop_now);
        m_under = pend_under | (m_under & ~c);
        pend_under = 0;
        m_over = (w & ~acc) | (m_over & ~c);
        #1;
        tick_no++;
        monitor();
    endtask

    task automatic wait_load(input int budget);
        int n = 0;
        while (!cur_load && n < budget) begin tick(0, '0, 0); n++; end
        check_eq("load_seen", cur_load, 1);
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        en = 0;
        while (!ose && n < budget) begin tick(0, '0, 0); n++; end
        check_eq("idle_seen", ose, 1);
    endtask

    task automatic reset_model();
        mcnt = 0; mq.delete(); m_under = 0; m_over = 0; pend_under = 0; cur_load = 0;
        in_word = 0; have_prev = 0; saw_idle = 1; mslot = 0; prev_ock = 0;
    endtask

    initial begin
        int t0, l0, n;
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_sdo", sdo, 0);   check_eq("rst_ock", ock, 0);
        check_eq("rst_old", old, 0);   check_eq("rst_fs", fs, 0);
        check_eq("rst_ose", ose, 1);   check_eq("rst_obe", obe, 1);
        check_eq("rst_cnt", fifo_cnt, 0);
        check_eq("rst_under", underrun, 0); check_eq("rst_over", overflow, 0);
        @(negedge clk);
        rst_n = 1;

        // Single word, MSB first, latency from write to load and first bit
        en = 1; clk_div = 0; len8 = 0; lsb_first = 0;
        tick(1, 16'hA5C3, 0);
        t0 = tick_no;
        tick(0, '0, 0);
        check_eq("lat_old", old_tick, t0 + 1);
        tick(0, '0, 0);
        check_eq("lat_sdo", sdo, 1);
        run_idle(200);

        // TDM frame, LSB first, then an underrun load in slot 0
        lsb_first = 1;
        tick(1, 16'h0001, 0);
        tick(1, 16'h8000, 0);
        en = 1;
        l0 = n_loads; n = 0;
        while (n_loads < l0 + 3 && n < 400) begin tick(0, '0, 0); n++; end
        check_eq("tdm_loads", n_loads, l0 + 3);
        run_idle(200);
        check_eq("tdm_underrun", underrun, 1);
        tick(0, '0, 1);

        // 8-bit words with a slower bit clock
        len8 = 1; lsb_first = 0; clk_div = 2; en = 1;
        tick(1, 16'h12F0, 0);
        wait_load(20);
        run_idle(200);

        // Overflow, clear losing to a simultaneous set, then drain in order
        len8 = 0; clk_div = 0;
        for (int i = 1; i <= 5; i++) tick(1, DW'(i), 0);
        check_eq("ovf_cnt", fifo_cnt, 4);
        check_eq("ovf_obe", obe, 0);
        check_eq("ovf_flag", overflow, 1);
        tick(1, 16'd6, 1);
        check_eq("ovf_clr_wins", overflow, 1);
        tick(0, '0, 1);
        check_eq("ovf_cleared", overflow, 0);
        en = 1; n = 0;
        while (mcnt > 0 && n < 400) begin tick(0, '0, 0); n++; end
        run_idle(200);
        check_eq("drain_no_under", underrun, 0);

        // Full FIFO with a write landing on the load tick
        for (int i = 0; i < 4; i++) tick(1, DW'($urandom), 0);
        en = 1;
        wait_load(20);
        tick(1, 16'hBEEF, 0);
        check_eq("fullpop_cnt", fifo_cnt, 4);
        check_eq("fullpop_over", overflow, 0);
        n = 0;
        while (mcnt > 0 && n < 800) begin tick(0, '0, 0); n++; end
        run_idle(200);

        // Randomized streams with gated clock enable and runtime config changes
        gaps = 1;
        for (int it = 0; it < 12; it++) begin
            clk_div = DIVW'($urandom_range(0, 2));
            len8 = 1'($urandom_range(0, 1)); lsb_first = 1'($urandom_range(0, 1));
            en = 0;
            for (int k = 0; k < int'($urandom_range(1, 5)); k++)
                tick(1, DW'($urandom), 1'($urandom_range(0, 3) == 0));
            en = 1; n = 0;
            while (mcnt > 0 && n < 3000) begin
                if (!cur_load && $urandom_range(0, 31) == 0) begin
                    clk_div = DIVW'($urandom_range(0, 2));
                    len8 = 1'($urandom_range(0, 1)); lsb_first = 1'($urandom_range(0, 1));
                end
                tick($urandom_range(0, 63) == 0, DW'($urandom), $urandom_range(0, 15) == 0);
                n++;
            end
            repeat ($urandom_range(0, 40)) tick(0, '0, 0);
            run_idle(1000);
            tick(0, '0, 1);
        end
        gaps = 0;

        // Reset in the middle of a word
        en = 1; clk_div = 1; len8 = 0;
        tick(1, 16'hFFFF, 0);
        n = 0;
        while (!(in_word && bit_idx > 2) && n < 100) begin tick(0, '0, 0); n++; end
        @(negedge clk);
        rst_n = 0;
        #1;
        check_eq("mid_rst_sdo", sdo, 0); check_eq("mid_rst_ock", ock, 0);
        check_eq("mid_rst_ose", ose, 1); check_eq("mid_rst_cnt", fifo_cnt, 0);
        check_eq("mid_rst_obe", obe, 1);
        reset_model();
        @(negedge clk);
        rst_n = 1;
        tick(1, 16'h3C5A, 0);
        wait_load(20);
        run_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
